fetch_unit: RTL

//   Requester side of the instruction memory interface: owns the program counter (PC), drives
//   the 8-bit fetch address and consumes the 9-bit instruction returned one cycle later.

---
 rtl/core_pkg.sv | 24 ++
 rtl/fetch_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the instruction-fetch path of the core.
//   CORE_AW / CORE_IW : default address (PC) and instruction widths
//   addr_t / instr_t  : typedefs at the default widths
//   CORE_START_PC     : default PC after reset
//   CORE_HALT_INSTR   : default encoding that stops fetch
//   fetch_state_e     : fetch sequencer states
package core_pkg;
  localparam int CORE_AW = 8;
  localparam int CORE_IW = 9;

  typedef logic [CORE_AW-1:0] addr_t;
  typedef logic [CORE_IW-1:0] instr_t;

  localparam addr_t  CORE_START_PC   = 8'h00;
  localparam instr_t CORE_HALT_INSTR = 9'h1FF;

  // FILL covers the single cycle after reset in which nothing valid is
  // in flight from memory yet.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the instruction memory address and
// hands {instruction, pc, valid} to decode with stall, redirect and halt.
//   clk           : clock, all state on posedge
//   reset_n       : asynchronous active-low reset
//   imem_addr     : fetch address to instruction memory (combinational)
//   imem_instr    : memory data for the address issued last cycle
//   stall         : decode cannot accept; hold the presented instruction
//   branch_take   : redirect, raised by decode when it accepts a branch
//   branch_target : redirect PC
//   instr_out     : instruction to decode, zero when not valid
//   instr_pc      : PC of instr_out
//   instr_valid   : instr_out is a real fetched instruction
//   halted        : halt instruction accepted, fetch stopped until reset
module fetch_unit
  import core_pkg::*;
#(
  parameter int             AW         = CORE_AW,
  parameter int             IW         = CORE_IW,
  parameter logic [AW-1:0]  START_PC   = CORE_START_PC,
  parameter logic [IW-1:0]  HALT_INSTR = CORE_HALT_INSTR
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_instr,
  input  logic          stall,
  input  logic          branch_take,
  input  logic [AW-1:0] branch_target,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  output logic          halted
);

  logic [AW-1:0] r_fetch_pc;   // next PC to issue
  logic [AW-1:0] r_req_pc;     // PC issued last cycle (now returning)
  logic          r_req_valid;
  fetch_state_e  r_state;

  logic [AW-1:0] w_addr;
  logic          w_valid;
  logic          w_accept;
  logic          w_redirect;
  logic          w_halt;

  assign w_valid    = r_req_valid && (r_state == RUN);
  assign w_accept   = w_valid && !stall;
  // A redirect only counts against a real instruction; this also makes it
  // a no-op in FILL and HALTED.
  assign w_redirect = w_valid && branch_take;
  assign w_halt     = w_accept && (imem_instr == HALT_INSTR);

  // Stall re-reads the in-flight address so the registered memory output
  // stays put; a redirect goes straight to the target (no wrong-path slot).
  always_comb begin
    w_addr = r_fetch_pc;
    case (r_state)
      HALTED:  w_addr = r_req_pc;
      RUN: begin
        if (w_redirect)  w_addr = branch_target;
        else if (stall)  w_addr = r_req_pc;
      end
      default: w_addr = r_fetch_pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc  <= START_PC;
      r_req_pc    <= START_PC;
      r_req_valid <= 1'b0;
      r_state     <= FILL;
    end else begin
      case (r_state)
        FILL: begin
          r_req_pc    <= w_addr;
          r_fetch_pc  <= w_addr + AW'(1);
          r_req_valid <= 1'b1;
          r_state     <= RUN;
        end
        RUN: begin
          if (w_halt) begin
            // req_pc is left alone so the memory address freezes on the
            // halt instruction's own PC.
            r_req_valid <= 1'b0;
            r_state     <= HALTED;
          end else if (w_accept || w_redirect) begin
            r_req_pc    <= w_addr;
            r_fetch_pc  <= w_addr + AW'(1);   // wraps modulo 2**AW
            r_req_valid <= 1'b1;
          end
        end
        default: ;  // HALTED holds until reset
      endcase
    end
  end

  assign imem_addr   = w_addr;
  assign instr_valid = w_valid;
  assign instr_out   = w_valid ? imem_instr : '0;
  assign instr_pc    = r_req_pc;
  assign halted      = (r_state == HALTED);

endmodule
